pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// pipeline_hazard_ctrl: per-stage stall/flush generation with memory-wait watchdog,
// debug halt/single-step and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
   parameter int unsigned WD_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  RA1_D,
   input  logic [2:0]  RA2_D,
   input  logic        SrcVec_D,
   input  logic [2:0]  WA_E,
   input  logic        MemtoReg_E,
   input  logic        ScalarWrite_E,
   input  logic        VectorWrite_E,
   input  logic        PCSrc_E,
   input  logic        MemReq_M,
   input  logic        MemReady_M,
   input  logic        halt_req,
   input  logic        step,
   input  logic        clr_count,
   output logic        Stall_F,
   output logic        Stall_D,
   output logic        Stall_E,
   output logic        Flush_D,
   output logic        Flush_E,
   output logic [15:0] stall_count,
   output logic        timeout_err,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [7:0] WD_LIM = 8'(WD_LIMIT);

   state_t      state_q, state_d;
   logic [7:0]  wd_q, wd_d;
   logic [15:0] cnt_q, cnt_d;
   logic        terr_q, terr_d;

   logic load_use, mem_busy;
   logic run_rules, release_rules, timeout_hit;
   logic raw_stall_f, raw_stall_d, raw_stall_e, raw_flush_d, raw_flush_e;

   assign load_use = MemtoReg_E
                   & ((~SrcVec_D & ScalarWrite_E) | (SrcVec_D & VectorWrite_E))
                   & ((WA_E == RA1_D) | (WA_E == RA2_D));
   assign mem_busy = MemReq_M & ~MemReady_M;

   always_comb begin
      state_d       = state_q;
      wd_d          = wd_q;
      run_rules     = 1'b0;
      release_rules = 1'b0;
      timeout_hit   = 1'b0;
      raw_stall_f   = 1'b0;
      raw_stall_d   = 1'b0;
      raw_stall_e   = 1'b0;
      raw_flush_d   = 1'b0;
      raw_flush_e   = 1'b0;

      case (state_q)
         RUN: run_rules = 1'b1;
         MEM_WAIT: begin
            if (mem_busy && (wd_q != WD_LIM)) begin
               raw_stall_f = 1'b1;
               raw_stall_d = 1'b1;
               raw_stall_e = 1'b1;
               wd_d        = wd_q + 8'd1;
            end else begin
               timeout_hit   = mem_busy;
               release_rules = 1'b1;
            end
         end
         HALT: begin
            if (step) begin
               run_rules = 1'b1;
            end else begin
               raw_stall_f = 1'b1;
               raw_stall_d = 1'b1;
               raw_stall_e = 1'b1;
               state_d     = halt_req ? HALT : RUN;
            end
         end
         default: state_d = RUN;
      endcase

      // A stepped HALT cycle and a MEM_WAIT exit share the normal RUN hazard rules.
      if (run_rules && mem_busy) begin
         raw_stall_f = 1'b1;
         raw_stall_d = 1'b1;
         raw_stall_e = 1'b1;
         state_d     = MEM_WAIT;
         wd_d        = 8'd0;
      end else if (run_rules || release_rules) begin
         if (PCSrc_E) begin
            raw_flush_d = 1'b1;
            raw_flush_e = 1'b1;
         end else if (load_use) begin
            raw_stall_f = 1'b1;
            raw_stall_d = 1'b1;
            raw_flush_e = 1'b1;
         end
         state_d = halt_req ? HALT : RUN;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      terr_d = terr_q | timeout_hit;
      if (clr_count) begin
         cnt_d  = 16'd0;
         terr_d = 1'b0;
      end else if (Stall_F && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         wd_q    <= 8'd0;
         cnt_q   <= 16'd0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   // Controls are forced low for the whole time reset is held, not just at the edge.
   assign Stall_F     = reset & raw_stall_f;
   assign Stall_D     = reset & raw_stall_d;
   assign Stall_E     = reset & raw_stall_e;
   assign Flush_D     = reset & raw_flush_d;
   assign Flush_E     = reset & raw_flush_e;
   assign stall_count = cnt_q;
   assign timeout_err = terr_q;
   assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// Scoreboard bench for pipeline_hazard_ctrl (WD_LIMIT = 8).
module tb_pipeline_hazard_ctrl;

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_MW   = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;
   // {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E}
   localparam logic [4:0] C_NONE = 5'b00000;
   localparam logic [4:0] C_LU   = 5'b11001;
   localparam logic [4:0] C_ALL  = 5'b11100;
   localparam logic [4:0] C_BR   = 5'b00011;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  RA1_D, RA2_D, WA_E;
   logic        SrcVec_D, MemtoReg_E, ScalarWrite_E, VectorWrite_E, PCSrc_E;
   logic        MemReq_M, MemReady_M, halt_req, step, clr_count;
   logic        Stall_F, Stall_D, Stall_E, Flush_D, Flush_E;
   logic [15:0] stall_count;
   logic        timeout_err;
   logic [1:0]  state;
   logic [4:0]  ctl;

   assign ctl = {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.WD_LIMIT(8)) dut (
      .clk(clk), .reset(reset),
      .RA1_D(RA1_D), .RA2_D(RA2_D), .SrcVec_D(SrcVec_D), .WA_E(WA_E),
      .MemtoReg_E(MemtoReg_E), .ScalarWrite_E(ScalarWrite_E),
      .VectorWrite_E(VectorWrite_E), .PCSrc_E(PCSrc_E),
      .MemReq_M(MemReq_M), .MemReady_M(MemReady_M),
      .halt_req(halt_req), .step(step), .clr_count(clr_count),
      .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
      .Flush_D(Flush_D), .Flush_E(Flush_E),
      .stall_count(stall_count), .timeout_err(timeout_err), .state(state)
   );

   typedef struct {
      string      tag;
      logic [4:0] ctl;
      logic [1:0] st;
   } exp_t;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      RA1_D = 3'd0; RA2_D = 3'd0; WA_E = 3'd0; SrcVec_D = 1'b0;
      MemtoReg_E = 1'b0; ScalarWrite_E = 1'b0; VectorWrite_E = 1'b0; PCSrc_E = 1'b0;
      MemReq_M = 1'b0; MemReady_M = 1'b0; halt_req = 1'b0; step = 1'b0; clr_count = 1'b0;
   endtask

   task automatic set_lu(input logic [2:0] ra1, input logic [2:0] ra2, input logic [2:0] wa);
      MemtoReg_E = 1'b1; ScalarWrite_E = 1'b1; SrcVec_D = 1'b0;
      RA1_D = ra1; RA2_D = ra2; WA_E = wa;
   endtask

   // Called at posedge+1 with inputs applied; checks mid-cycle, returns at next posedge+1.
   task automatic cyc(input string tag, input logic [4:0] e_ctl, input logic [1:0] e_st);
      exp_t e, g;
      e.tag = tag; e.ctl = e_ctl; e.st = e_st;
      sb_q.push_back(e);
      #3;
      g = sb_q.pop_front();
      chk({g.tag, "_ctl"}, 32'(ctl), 32'(g.ctl));
      chk({g.tag, "_st"}, 32'(state), 32'(g.st));
      chk({g.tag, "_se_fe"}, 32'(Stall_E & Flush_E), 32'(1'b0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=running want=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      clr_in();
      reset = 1'b0;
      @(posedge clk);
      #1;
      MemReq_M = 1'b1; PCSrc_E = 1'b1; halt_req = 1'b1; step = 1'b1;
      set_lu(3'd3, 3'd3, 3'd3);
      #3;
      chk("rst_ctl", 32'(ctl), 32'(C_NONE));
      chk("rst_st", 32'(state), 32'(S_RUN));
      chk("rst_cnt", 32'(stall_count), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_st", 32'(state), 32'(S_RUN));
      clr_in();
      reset = 1'b1;

      cyc("idle", C_NONE, S_RUN);
      set_lu(3'd5, 3'd3, 3'd3);
      cyc("lu", C_LU, S_RUN);
      clr_in();
      cyc("lu_after", C_NONE, S_RUN);
      chk("lu_cnt", 32'(stall_count), 32'd1);

      set_lu(3'd5, 3'd3, 3'd3);
      SrcVec_D = 1'b1;
      cyc("vmis", C_NONE, S_RUN);
      VectorWrite_E = 1'b1;
      cyc("vmat", C_LU, S_RUN);
      clr_in();
      set_lu(3'd6, 3'd1, 3'd6);
      cyc("lu_ra1", C_LU, S_RUN);
      MemtoReg_E = 1'b0;
      cyc("nomem", C_NONE, S_RUN);
      MemtoReg_E = 1'b1; PCSrc_E = 1'b1;
      cyc("br_lu", C_BR, S_RUN);
      clr_in();
      chk("cnt3", 32'(stall_count), 32'd3);
      clr_count = 1'b1;
      cyc("clr", C_NONE, S_RUN);
      clr_count = 1'b0;
      chk("clr_cnt", 32'(stall_count), 32'd0);

      MemReq_M = 1'b1;
      for (int i = 0; i < 4; i++) cyc("mw", C_ALL, (i == 0) ? S_RUN : S_MW);
      MemReady_M = 1'b1;
      cyc("mw_rdy", C_NONE, S_MW);
      clr_in();
      cyc("mw_post", C_NONE, S_RUN);
      chk("mw_cnt", 32'(stall_count), 32'd4);

      MemReq_M = 1'b1;
      cyc("mwl0", C_ALL, S_RUN);
      cyc("mwl1", C_ALL, S_MW);
      MemReady_M = 1'b1;
      set_lu(3'd0, 3'd3, 3'd3);
      cyc("mw_lu", C_LU, S_MW);
      clr_in();
      cyc("mwl_post", C_NONE, S_RUN);
      chk("mwl_cnt", 32'(stall_count), 32'd7);
      clr_count = 1'b1;
      cyc("clr2", C_NONE, S_RUN);
      clr_count = 1'b0;

      MemReq_M = 1'b1;
      cyc("wd_run", C_ALL, S_RUN);
      for (int i = 0; i < 8; i++) cyc("wd_wait", C_ALL, S_MW);
      chk("wd_terr_pre", 32'(timeout_err), 32'd0);
      cyc("wd_hit", C_NONE, S_MW);
      chk("wd_terr", 32'(timeout_err), 32'd1);
      clr_in();
      cyc("wd_post", C_NONE, S_RUN);
      chk("wd_cnt", 32'(stall_count), 32'd9);
      chk("wd_sticky", 32'(timeout_err), 32'd1);
      clr_count = 1'b1;
      cyc("wd_clr", C_NONE, S_RUN);
      clr_count = 1'b0;
      chk("wd_clr_terr", 32'(timeout_err), 32'd0);
      chk("wd_clr_cnt", 32'(stall_count), 32'd0);

      halt_req = 1'b1;
      cyc("h1", C_NONE, S_RUN);
      cyc("h2", C_ALL, S_HALT);
      step = 1'b1;
      cyc("h3_step", C_NONE, S_HALT);
      step = 1'b0;
      cyc("h4", C_ALL, S_HALT);
      cyc("h5", C_ALL, S_HALT);
      step = 1'b1;
      cyc("h6_step", C_NONE, S_HALT);
      step = 1'b0;
      cyc("h7", C_ALL, S_HALT);
      halt_req = 1'b0;
      cyc("h8", C_ALL, S_HALT);
      cyc("h9", C_NONE, S_RUN);

      halt_req = 1'b1;
      cyc("hs0", C_NONE, S_RUN);
      cyc("hs1", C_ALL, S_HALT);
      step = 1'b1; MemReq_M = 1'b1;
      cyc("hs_busy", C_ALL, S_HALT);
      step = 1'b0;
      cyc("hs_mw", C_ALL, S_MW);
      MemReady_M = 1'b1;
      cyc("hs_rdy", C_NONE, S_MW);
      MemReq_M = 1'b0; MemReady_M = 1'b0;
      cyc("hs_back", C_ALL, S_HALT);
      halt_req = 1'b0;
      cyc("hs_rel", C_ALL, S_HALT);
      cyc("hs_run", C_NONE, S_RUN);

      MemReq_M = 1'b1;
      cyc("rmw0", C_ALL, S_RUN);
      cyc("rmw1", C_ALL, S_MW);
      reset = 1'b0; PCSrc_E = 1'b1;
      #2;
      chk("rmw_ctl", 32'(ctl), 32'(C_NONE));
      chk("rmw_st", 32'(state), 32'(S_RUN));
      chk("rmw_cnt", 32'(stall_count), 32'd0);
      @(posedge clk);
      #1;
      clr_in();
      reset = 1'b1;
      cyc("rmw_after", C_NONE, S_RUN);

      halt_req = 1'b1;
      cyc("rh0", C_NONE, S_RUN);
      cyc("rh1", C_ALL, S_HALT);
      reset = 1'b0;
      #2;
      chk("rh_ctl", 32'(ctl), 32'(C_NONE));
      chk("rh_st", 32'(state), 32'(S_RUN));
      @(posedge clk);
      #1;
      clr_in();
      reset = 1'b1;
      cyc("rh_after", C_NONE, S_RUN);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
